// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider for the RV32M path.
// Executes DIV, DIVU, REM and REMU, one conditional subtract-and-shift
// step per clock, with the RISC-V results for divide-by-zero and for
// signed overflow.
//
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   reset     - asynchronous active-high reset, clears all state
//   start     - request strobe, accepted in IDLE or DONE
//   op        - 00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start)
//   dividend  - rs1 value (sampled with start)
//   divisor   - rs2 value (sampled with start)
//   busy      - high while iterating (CALC)
//   done      - one-cycle pulse, result valid in the same cycle
//   result    - quotient or remainder, held until the next completion
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_q;
  // Holds the dividend magnitude; its MSBs shift out into the partial
  // remainder while quotient bits shift in from the bottom.
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic             is_rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             overflow;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] final_quo;
  logic [WIDTH-1:0] final_rem;

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

  // Operand decode at capture: magnitudes for signed ops and the two
  // special cases that skip iteration entirely.
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & dividend[WIDTH-1];
    b_neg     = is_signed & divisor[WIDTH-1];
    a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
    div_zero  = (divisor == '0);
    overflow  = is_signed && (dividend == MOST_NEG) && (divisor == '1);
  end

  // One restoring step. The remainder is always below the divisor, so the
  // shifted value fits in WIDTH+1 bits and bit WIDTH of the difference is
  // a reliable sign.
  always_comb begin
    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial     = shifted - {1'b0, dsr_q};
    take      = ~trial[WIDTH];
    rem_next  = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], take};
    final_quo = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
    final_rem = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
  end

  // Control and datapath registers. IDLE and DONE share the capture path
  // so a start in the DONE cycle issues back-to-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        S_CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (count == LAST_ITER) begin
            result <= is_rem_q ? final_rem : final_quo;
            count  <= '0;
            state  <= S_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          if (start) begin
            if (div_zero) begin
              result <= op[1] ? dividend : '1;
              state  <= S_DONE;
            end else if (overflow) begin
              result <= op[1] ? '0 : dividend;
              state  <= S_DONE;
            end else begin
              rem_q     <= '0;
              quo_q     <= a_mag;
              dsr_q     <= b_mag;
              is_rem_q  <= op[1];
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              count     <= '0;
              state     <= S_CALC;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (WIDTH=32).
// Directed table of vectors, hand-written multi-cycle sequences
// (ignored start, back-to-back issue, abort by reset) and random
// operations checked against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int total = 0;
  int bad = 0;
  logic [W-1:0] prev_result;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[15];

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges beyond every local bound.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: RISC-V division semantics written directly in integer math.
  function automatic logic [W-1:0] ref_div(input logic [1:0] o,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == 0) return o[1] ? a : {W{1'b1}};
    if (!o[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sa == -(longint'(1) << (W - 1)) && sb == -1) return o[1] ? '0 : a;
      q = sa / sb;
      r = sa % sb;
      return o[1] ? r[W-1:0] : q[W-1:0];
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [1:0] o,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    if (b == 0) return 0;
    if (!o[0] && a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) return 0;
    return W;
  endfunction

  // Single comparison with failure reporting.
  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
    end
  endtask

  // Present one request for a single cycle; returns at the negedge after
  // the edge that sampled it.
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    @(negedge clk);
    prev_result = result;
    start = 1'b1;
    op = o;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
  endtask

  // Step negedges until done, counting busy cycles and watching that
  // result stays put until completion.
  task automatic waitDone(output int lat, output int busy_cnt,
                          output bit held);
    lat = 0;
    busy_cnt = 0;
    held = 1'b1;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (result !== prev_result) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!done) checkOutput("timeout_waiting_done", {31'd0, done}, 1);
  endtask

  task automatic runOp(input string name, input logic [1:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int exp_lat);
    int lat, bc;
    bit held;
    applyStimulus(o, a, b);
    waitDone(lat, bc, held);
    checkOutput({name, "_result"}, result, exp);
    checkOutput({name, "_latency"}, lat, exp_lat);
    checkOutput({name, "_busy_cycles"}, bc, exp_lat);
    checkOutput({name, "_busy_at_done"}, {31'd0, busy}, 0);
    if (exp_lat > 0) checkOutput({name, "_result_held"}, {31'd0, held}, 1);
    @(negedge clk);
    checkOutput({name, "_done_pulse"}, {31'd0, done}, 0);
  endtask

  // Main sequence: reset, directed table, multi-cycle corners, random.
  initial begin
    int lat, bc, done_cnt;
    bit held;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{2'b01, 32'd1000, 32'd10, 32'd100, 32};
    vecs[1]  = '{2'b11, 32'd1000, 32'd10, 32'd0, 32};
    vecs[2]  = '{2'b11, 32'd1003, 32'd10, 32'd3, 32};
    vecs[3]  = '{2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32};
    vecs[4]  = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32};
    vecs[5]  = '{2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32};
    vecs[6]  = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32};
    vecs[7]  = '{2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32};
    vecs[8]  = '{2'b00, 32'd5, 32'd0, 32'hFFFFFFFF, 0};
    vecs[9]  = '{2'b11, 32'd5, 32'd0, 32'd5, 0};
    vecs[10] = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    vecs[11] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0};
    vecs[12] = '{2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 0};
    vecs[13] = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32};
    vecs[14] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32};

    reset = 1'b1;
    start = 1'b0;
    op = 2'b00;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_done", {31'd0, done}, 0);
    checkOutput("reset_result", result, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_busy", {31'd0, busy}, 0);
    checkOutput("post_reset_done", {31'd0, done}, 0);

    for (int i = 0; i < 15; i++)
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].exp, vecs[i].lat);

    // A start during CALC is ignored; a start in the DONE cycle issues.
    applyStimulus(2'b01, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    dividend = 32'd50;
    divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, bc, held);
    checkOutput("ignore_start_result", result, 32'd14);
    checkOutput("ignore_start_latency", lat, 22);
    checkOutput("ignore_start_held", {31'd0, held}, 1);
    prev_result = result;
    start = 1'b1;
    op = 2'b01;
    dividend = 32'd9;
    divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_busy_after_issue", {31'd0, busy}, 1);
    waitDone(lat, bc, held);
    checkOutput("b2b_result", result, 32'd3);
    checkOutput("b2b_latency", lat, 32);
    checkOutput("b2b_held", {31'd0, held}, 1);
    @(negedge clk);

    // Asynchronous reset between edges aborts an operation in flight.
    applyStimulus(2'b01, 32'd1000, 32'd10);
    repeat (15) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 0);
    checkOutput("abort_done", {31'd0, done}, 0);
    checkOutput("abort_result", result, 0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("abort_no_done", done_cnt, 0);
    runOp("after_abort", 2'b01, 32'd50, 32'd5, 32'd10, 32);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = '1; end
        2: rb = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 15))
                                            : -32'($urandom_range(1, 15));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      runOp($sformatf("rand%0d", i), ro, ra, rb, ref_div(ro, ra, rb),
            ref_lat(ro, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Iterative radix-2 restoring divider for the sail-core RV32M path. It is the subtract-side counterpart of the core adder: one conditional subtract-and-shift step per cycle. It executes DIV, DIVU, REM and REMU with RISC-V-defined corner-case results. It sits beside the ALU, and the core stalls on busy.

Parameters:
WIDTH, 32, operand and result width in bits; legal for any WIDTH >= 4.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
start  input  1  request strobe; sampled only when the block can accept.
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
dividend  input  WIDTH  rs1 value; sampled with start.
divisor  input  WIDTH  rs2 value; sampled with start.
busy  output  1  high while an operation is in progress (CALC state).
done  output  1  one-cycle pulse; result valid in the same cycle.
result  output  WIDTH  quotient or remainder; held until the next accepted start.

Behaviour:
- Reset values: busy=0, done=0, result=0, state=IDLE, iteration count=0, internal registers=0.
- Reset asserted mid-operation aborts the operation. No done is issued. The block returns to IDLE.
- States:
  - IDLE: waits for start.
  - CALC: performs one iteration per cycle.
  - DONE: asserts done for exactly one cycle.
- Start acceptance: start is accepted at a rising edge when the state is IDLE or DONE, so back-to-back issue is allowed. At that edge op, dividend and divisor are latched. start while in CALC is ignored; there is no queuing and the inputs are not sampled.
- Signed ops (DIV, REM):
  - Operands are converted to magnitudes at capture.
  - Quotient sign = sign(dividend) XOR sign(divisor).
  - Remainder sign = sign(dividend).
  - Negation is applied when the result register is written.
- Unsigned ops (DIVU, REMU) use the operands unmodified.
- Special cases are decided at capture and bypass CALC: the next state is DONE, giving latency 1 cycle.
  - divisor==0: quotient = all ones (-1); remainder = dividend, unmodified and for either signedness.
  - Signed overflow (dividend = most-negative value, divisor = -1, DIV/REM only): quotient = dividend; remainder = 0.
- Normal path:
  - Each CALC cycle shifts the partial remainder left by one, bringing in the next dividend MSB.
  - It then trial-subtracts the divisor magnitude using a WIDTH+1-bit difference.
  - If the difference is non-negative, the partial remainder takes the difference and quotient bit 1 is shifted in; otherwise quotient bit 0 is shifted in.
  - The iteration count runs 0..WIDTH-1. The edge that completes iteration WIDTH-1 writes result (sign-corrected quotient or remainder per op) and moves to DONE.
- Latency:
  - Start accepted at edge n: busy=1 after edges n .. n+WIDTH-1, and busy=0 after edge n+WIDTH.
  - done=1 and result valid during the cycle following edge n+WIDTH.
  - With WIDTH=32, done follows the accepting edge by 32 cycles.
- done is high only in DONE. busy and done are never high together.
- The next edge leaves DONE, going to IDLE, or to CALC/DONE if start is high.
- result changes only on the edge that enters DONE. It remains stable otherwise, including while in IDLE and CALC.
- Arithmetic is modulo 2^WIDTH. No flags are produced.

Test Plan:
1. Reset asserted, then released → busy=0, done=0, result=0. Reassert reset asynchronously between clock edges → outputs clear before the next edge.
2. DIVU 1000/10, start for one cycle → busy for 32 cycles, done pulse for 1 cycle, result=100. Same operands with REMU → result=0. REMU 1003/10 → 3.
3. DIV -7/2 → result=-3 (0xFFFFFFFD). REM -7/2 → -1 (0xFFFFFFFF). DIV 7/-2 → -3. REM 7/-2 → 1. DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
4. Corner cases, each with done one cycle after start:
   - DIV 5/0 → 0xFFFFFFFF.
   - REMU 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
   - REM with the same operands → 0.
5. Start DIVU 100/7; pulse start again with different operands 10 cycles later → ignored; the single done gives result=14. Assert start in the DONE cycle with DIVU 9/3 → second done 32 cycles later with result=3.
6. Assert reset 15 cycles into DIVU 1000/10 → busy=0 immediately. No done appears over the next 40 cycles. A fresh DIVU 50/5 then yields result=10.
